uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
- Serial-to-parallel UART receiver, directly upstream of the UART RX command interpreter.
- Oversamples iUART_RX on a 16x baud tick and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB-first, checks the stop bit, then presents the byte on oser2par with a one-cycle oUART_RX_STOP strobe.
- The command interpreter decodes 'w' (0x77) and 'r' (0x72) frames from these bytes.

Parameters:
- OVERSAMPLE, 16, ticks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per frame.
- SYNC_STAGES, 2, flops in the iUART_RX synchronizer; >= 2.

Ports:
- iCLK  input  1  system clock.
- iRESET  input  1  synchronous reset, active-high.
- iUART_RX  input  1  asynchronous serial line; idle high.
- iUART_RX_TICK  input  1  one-iCLK-cycle pulse at OVERSAMPLE x baud, from the baud generator.
- iUART_RX_EN  input  1  receiver enable.
- oser2par  output  DATA_BITS  last good received byte; holds until the next good frame.
- oUART_RX_STOP  output  1  one-cycle strobe: oser2par has just been updated with a good frame.
- oUART_RX_FERR  output  1  one-cycle strobe: framing error (stop bit sampled low).
- oUART_RX_BUSY  output  1  high while state != IDLE.

Behaviour:
- Reset (iRESET high at a posedge iCLK):
  - state = IDLE, tick counter = 0, bit counter = 0, shift register = 0.
  - Synchronizer flops = 1.
  - oser2par = 0, oUART_RX_STOP = 0, oUART_RX_FERR = 0, oUART_RX_BUSY = 0.
  - Reset mid-frame discards the partial byte, with no strobe.
- Synchronizer:
  - rx_s is iUART_RX delayed by SYNC_STAGES flops.
  - All sampling below uses rx_s.
- Counters:
  - Tick counter is $clog2(OVERSAMPLE) bits wide and advances only on cycles where iUART_RX_TICK = 1.
  - Bit counter is $clog2(DATA_BITS+1) bits wide.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s = 0 (sampled on any iCLK cycle with iUART_RX_EN = 1), go to START and clear the tick counter.
  - START: on the tick where tick counter = OVERSAMPLE/2-1 (mid start bit):
    - rx_s = 0: clear the tick counter and go to DATA.
    - rx_s = 1: glitch; go to IDLE with no strobe.
  - DATA: on the tick where tick counter = OVERSAMPLE-1:
    - Shift rx_s into the MSB of the shift register (right-shift, so data is LSB-first).
    - Increment the bit counter.
    - After DATA_BITS samples, go to STOP.
  - STOP: on the tick where tick counter = OVERSAMPLE-1:
    - rx_s = 1: load oser2par from the shift register, pulse oUART_RX_STOP for one iCLK cycle, go to IDLE.
    - rx_s = 0: pulse oUART_RX_FERR, leave oser2par unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s = 1, then go to IDLE. This absorbs break conditions without producing false starts.
- Latency: strobe asserts on the iCLK cycle after the tick that samples the stop bit. oser2par is valid in that same cycle.
- Back-to-back frames: returning to IDLE at mid stop bit lets a start edge in the second half of the stop bit be caught.
- Enable:
  - iUART_RX_EN = 0 forces state to IDLE on the next iCLK and suppresses both strobes.
  - oser2par holds its value.
  - Re-enabling while the line is low does not start a frame until rx_s has been seen high in IDLE. An armed flag is cleared by disable and set by rx_s = 1.
- Simultaneous events: iUART_RX_EN falling on a stop-sample tick gives no strobe (disable wins). Reset wins over everything.
- STOP and FERR are never high in the same cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled on the tick where tick counter = OVERSAMPLE-1.
  - Even parity is checked.
  - Adds output oUART_RX_PERR, a one-cycle strobe coincident with the point the stop bit is sampled.
  - A parity-bad frame with a good stop bit still does not update oser2par and does not pulse oUART_RX_STOP. It pulses oUART_RX_PERR only, then goes to IDLE.
- Undefined: no PARITY state and no oUART_RX_PERR port; frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - UART_OVERSAMPLE_DEF = 16 and UART_DATA_BITS_DEF = 8;
  - the command byte constants CMD_WR = 8'h77, CMD_RD = 8'h72, CMD_SP = 8'h20, CMD_CR = 8'h0D, shared with the command interpreter.
- One sub-module: uart_rx_sync, a parameterized SYNC_STAGES flop chain with reset value 1.

Test Plan:
- Send 8N1 0x77 at 16 ticks/bit, with iUART_RX_TICK every 4 iCLK:
  - oUART_RX_STOP pulses exactly once for 1 cycle, oser2par = 0x77, oUART_RX_FERR = 0.
  - oUART_RX_BUSY falls in the same cycle.
- Send 0x72 then 0x0D back-to-back with no idle gap: two STOP strobes, oser2par = 0x72 then 0x0D.
- Drive a 5-tick low glitch on an idle line: no strobe, BUSY returns to 0 within 8 ticks, oser2par unchanged.
- Send 0x55 with stop bit low, then hold the line low for 40 ticks:
  - one FERR strobe, oser2par keeps its prior value;
  - FSM stays in WAIT_IDLE until the line goes high;
  - the next 0x20 frame is received correctly.
- Deassert iUART_RX_EN mid-frame at data bit 3, and separately assert iRESET mid-frame:
  - no strobe in either case;
  - after re-enable (or reset release), the next frame 0x41 is received correctly.
- With UART_RX_PARITY_EN: send 0xA5 with correct even parity bit 0, then 0xA5 with parity bit 1:
  - first frame: STOP strobe, oser2par = 0xA5;
  - second frame: PERR strobe only, oser2par stays 0xA5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path and the command interpreter.
// Contents:
//   rx_state_t           receiver FSM state encoding
//   UART_OVERSAMPLE_DEF  default ticks per bit period
//   UART_DATA_BITS_DEF   default data bits per frame
//   CMD_*                command bytes decoded by the interpreter
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE_DEF = 16;
    localparam int unsigned UART_DATA_BITS_DEF  = 8;

    localparam logic [7:0] CMD_WR = 8'h77;
    localparam logic [7:0] CMD_RD = 8'h72;
    localparam logic [7:0] CMD_SP = 8'h20;
    localparam logic [7:0] CMD_CR = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line.
// Flops reset to 1 so a reset never looks like a start bit.
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   rx_async asynchronous serial line
//   rx_s     line delayed by SYNC_STAGES flops
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_async};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: oversamples the serial line, validates the start bit at
// mid-bit, shifts data LSB-first and checks the stop bit.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit and oUART_RX_PERR.
// Ports:
//   iCLK, iRESET   clock, synchronous active-high reset
//   iUART_RX       asynchronous serial line (idle high)
//   iUART_RX_TICK  one-cycle pulse at OVERSAMPLE x baud
//   iUART_RX_EN    receiver enable
//   oser2par       last good received byte
//   oUART_RX_STOP  strobe: oser2par just updated
//   oUART_RX_FERR  strobe: stop bit sampled low
//   oUART_RX_PERR  strobe: parity error (parity build only)
//   oUART_RX_BUSY  high while the FSM is not idle
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS   = UART_DATA_BITS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iUART_RX,
    input  logic                 iUART_RX_TICK,
    input  logic                 iUART_RX_EN,
    output logic [DATA_BITS-1:0] oser2par,
    output logic                 oUART_RX_STOP,
    output logic                 oUART_RX_FERR,
`ifdef UART_RX_PARITY_EN
    output logic                 oUART_RX_PERR,
`endif
    output logic                 oUART_RX_BUSY
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_n;
    logic [TW-1:0]        tick_q, tick_n;
    logic [BW-1:0]        bit_q, bit_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 stop_q, stop_n;
    logic                 ferr_q, ferr_n;
    logic                 armed_q, armed_n;
    logic                 at_last;
`ifdef UART_RX_PARITY_EN
    logic                 par_ok_q, par_ok_n;
    logic                 perr_q, perr_n;
`endif

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (iCLK),
        .rst      (iRESET),
        .rx_async (iUART_RX),
        .rx_s     (rx_s)
    );

    assign at_last = iUART_RX_TICK && (tick_q == TICK_LAST);

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            stop_q   <= 1'b0;
            ferr_q   <= 1'b0;
            armed_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            tick_q   <= tick_n;
            bit_q    <= bit_n;
            shift_q  <= shift_n;
            data_q   <= data_n;
            stop_q   <= stop_n;
            ferr_q   <= ferr_n;
            armed_q  <= armed_n;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= par_ok_n;
            perr_q   <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q;
        bit_n    = bit_q;
        shift_n  = shift_q;
        data_n   = data_q;
        stop_n   = 1'b0;
        ferr_n   = 1'b0;
        armed_n  = armed_q;
`ifdef UART_RX_PARITY_EN
        par_ok_n = par_ok_q;
        perr_n   = 1'b0;
`endif

        // Wrap explicitly so non-power-of-two OVERSAMPLE values still work.
        if (iUART_RX_TICK) begin
            tick_n = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        end

        // Disable overrides everything: no strobes, and the receiver must
        // see an idle-high line again before it accepts a start bit.
        if (!iUART_RX_EN) begin
            state_n = IDLE;
            armed_n = 1'b0;
            tick_n  = '0;
            bit_n   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed_q) begin
                        state_n = START;
                        tick_n  = '0;
                        bit_n   = '0;
                    end
                end
                START: begin
                    if (iUART_RX_TICK && (tick_q == TICK_MID)) begin
                        if (!rx_s) begin
                            tick_n  = '0;
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (at_last) begin
                        shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_n   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            bit_n   = '0;
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_last) begin
                        par_ok_n = ~(^shift_q ^ rx_s);
                        state_n  = STOP;
                    end
                end
`endif
                STOP: begin
                    if (at_last) begin
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_ok_q) begin
                                data_n = shift_q;
                                stop_n = 1'b1;
                            end else begin
                                perr_n = 1'b1;
                            end
`else
                            data_n = shift_q;
                            stop_n = 1'b1;
`endif
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign oser2par      = data_q;
    assign oUART_RX_STOP = stop_q;
    assign oUART_RX_FERR = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign oUART_RX_PERR = perr_q;
`endif
    assign oUART_RX_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: table of frames, hand-written corner sequences
// (glitch, break, disable, reset, parity) and randomized frames checked
// against a frame-level model of the expected byte and strobes.
module tb_uart_rx_deser;
    import uart_pkg::*;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       rx   = 1'b1;
    logic       tick = 1'b0;
    logic       en   = 1'b1;
    logic [7:0] dout;
    logic       stop, ferr, busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    uart_rx_deser #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .iCLK          (clk),
        .iRESET        (rst),
        .iUART_RX      (rx),
        .iUART_RX_TICK (tick),
        .iUART_RX_EN   (en),
        .oser2par      (dout),
        .oUART_RX_STOP (stop),
        .oUART_RX_FERR (ferr),
`ifdef UART_RX_PARITY_EN
        .oUART_RX_PERR (perr),
`endif
        .oUART_RX_BUSY (busy)
    );

    always #5 clk = ~clk;

    // Tick high for exactly one posedge out of every four.
    initial begin
        forever begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    end

    int   total = 0;
    int   bad = 0;
    int   stop_cnt = 0;
    int   ferr_cnt = 0;
    int   perr_cnt = 0;
    logic stop_prev = 1'b0;
    logic [7:0] last_good;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor: counts strobes and checks per-strobe properties.
    always @(negedge clk) begin
        if (!rst) begin
            if (stop) begin
                stop_cnt++;
                check("stop_busy_low", {31'd0, busy}, 32'd0);
                check("stop_ferr_excl", {31'd0, ferr}, 32'd0);
                check("stop_width", {31'd0, stop_prev}, 32'd0);
            end
            if (ferr) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (perr) perr_cnt++;
`endif
        end
        stop_prev = stop;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    // Start, data LSB-first, optional parity, stop; line left at stop level.
    task automatic send_bits(input logic [7:0] d, input logic par, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) $display("parity arg unknown");
`endif
        drive_bit(stopb);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic par_bad,
                             input logic stopb, input int gap, input int exp_stop,
                             input int exp_ferr, input int exp_perr, input logic [7:0] exp_data);
        int s0, f0, p0;
        s0 = stop_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_bits(d, (^d) ^ par_bad, stopb);
        rx = 1'b1;
        wait_ticks(gap);
        check($sformatf("%s_stop", name), stop_cnt - s0, exp_stop);
        check($sformatf("%s_ferr", name), ferr_cnt - f0, exp_ferr);
        check($sformatf("%s_data", name), {24'd0, dout}, {24'd0, exp_data});
`ifdef UART_RX_PARITY_EN
        check($sformatf("%s_perr", name), perr_cnt - p0, exp_perr);
`else
        if (p0 != perr_cnt || exp_perr != 0) $display("perr count moved without parity");
`endif
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap;
        int         exp_stop;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int s0, f0;
        logic [7:0] d;
        logic sb, pb;
        int gap, es, ef, ep;

        tbl[0] = '{CMD_WR, 1'b1, 2, 1, 0, 8'h77};
        tbl[1] = '{CMD_RD, 1'b1, 0, 1, 0, 8'h72};
        tbl[2] = '{CMD_CR, 1'b1, 3, 1, 0, 8'h0D};
        tbl[3] = '{8'h55,  1'b0, 4, 0, 1, 8'h0D};
        tbl[4] = '{CMD_SP, 1'b1, 1, 1, 0, 8'h20};
        tbl[5] = '{8'h00,  1'b1, 0, 1, 0, 8'h00};
        tbl[6] = '{8'hFF,  1'b1, 2, 1, 0, 8'hFF};
        tbl[7] = '{8'h80,  1'b0, 4, 0, 1, 8'hFF};
        tbl[8] = '{8'h01,  1'b1, 2, 1, 0, 8'h01};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_data", {24'd0, dout}, 32'd0);
        check("rst_stop", {31'd0, stop}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_ticks(4);

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].data, 1'b0, tbl[i].stop_bit, tbl[i].gap,
                      tbl[i].exp_stop, tbl[i].exp_ferr, 0, tbl[i].exp_data);
        end
        last_good = 8'h01;

        // Short low glitch on an idle line
        s0 = stop_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_ticks(5);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_ticks(8);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_nostrobe", (stop_cnt - s0) + (ferr_cnt - f0), 32'd0);
        check("glitch_data", {24'd0, dout}, {24'd0, last_good});

        // Framing error followed by a long break
        s0 = stop_cnt; f0 = ferr_cnt;
        send_bits(8'h55, ^8'h55, 1'b0);
        wait_ticks(40);
        check("brk_ferr", ferr_cnt - f0, 32'd1);
        check("brk_stop", stop_cnt - s0, 32'd0);
        check("brk_busy", {31'd0, busy}, 32'd1);
        check("brk_data", {24'd0, dout}, {24'd0, last_good});
        rx = 1'b1;
        wait_ticks(2);
        check("brk_idle", {31'd0, busy}, 32'd0);
        run_frame("after_brk", CMD_SP, 1'b0, 1'b1, 2, 1, 0, 0, CMD_SP);
        last_good = CMD_SP;

        // Disable at data bit 3, then re-enable with the line held low
        s0 = stop_cnt; f0 = ferr_cnt;
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        en = 1'b0;
        @(negedge clk); @(negedge clk);
        check("dis_busy", {31'd0, busy}, 32'd0);
        for (int i = 3; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(1'b1);
        rx = 1'b0;
        wait_ticks(4);
        en = 1'b1;
        wait_ticks(20);
        check("reen_low_busy", {31'd0, busy}, 32'd0);
        check("dis_nostrobe", (stop_cnt - s0) + (ferr_cnt - f0), 32'd0);
        check("dis_data", {24'd0, dout}, {24'd0, last_good});
        rx = 1'b1;
        wait_ticks(4);
        run_frame("after_dis", 8'h41, 1'b0, 1'b1, 2, 1, 0, 0, 8'h41);

        // Reset mid-frame
        s0 = stop_cnt; f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check("mrst_data", {24'd0, dout}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        rx = 1'b1;
        wait_ticks(20);
        check("mrst_nostrobe", (stop_cnt - s0) + (ferr_cnt - f0), 32'd0);
        run_frame("after_rst", 8'h41, 1'b0, 1'b1, 2, 1, 0, 0, 8'h41);
        last_good = 8'h41;

`ifdef UART_RX_PARITY_EN
        run_frame("par_good", 8'hA5, 1'b0, 1'b1, 2, 1, 0, 0, 8'hA5);
        run_frame("par_bad", 8'hA5, 1'b1, 1'b1, 2, 0, 0, 1, 8'hA5);
        last_good = 8'hA5;
`endif

        // Randomized frames against the frame-level model
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            pb = ($urandom_range(0, 3) == 0);
`else
            pb = 1'b0;
`endif
            gap = sb ? int'($urandom_range(0, 3)) : 4;
            es = 0; ef = 0; ep = 0;
            if (!sb) ef = 1;
            else if (pb) ep = 1;
            else begin
                es = 1;
                last_good = d;
            end
            run_frame($sformatf("rnd%0d", i), d, pb, sb, gap, es, ef, ep, last_good);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
